// File: rtl/vga_sync_gen_pkg.sv
// Shared types and default 640x480@60 timing for the VGA raster generator.
package vga_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } phase_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam bit DEF_SYNC_POL = 1'b0;

  // Counter width for a 0..total-1 range, never narrower than one bit.
  function automatic int cnt_w(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Pixel tick in, raster position and sync levels out.
interface vga_sync_gen_if #(
  parameter int HW = 10,
  parameter int VW = 10
);
  logic          pix_en;
  logic          hsync;
  logic          vsync;
  logic          video_on;
  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic          frame_start;

  modport master (
    input  pix_en,
    output hsync, vsync, video_on, hcount, vcount, frame_start
  );

  modport slave (
    output pix_en,
    input  hsync, vsync, video_on, hcount, vcount, frame_start
  );
endinterface

// File: rtl/vga_sync_gen_axis_timer.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase tracker.
module vga_axis_timer
  import vga_pkg::*;
#(
  parameter int L_ACTIVE = DEF_H_ACTIVE,
  parameter int L_FP     = DEF_H_FP,
  parameter int L_SYNC   = DEF_H_SYNC,
  parameter int L_BP     = DEF_H_BP,
  localparam int TOTAL   = L_ACTIVE + L_FP + L_SYNC + L_BP,
  localparam int CW      = cnt_w(TOTAL)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          step,
  output logic [CW-1:0] count,
  output phase_t        phase,
  output phase_t        phase_nxt,
  output logic          wrap
);

  if (L_ACTIVE < 1 || L_FP < 1 || L_SYNC < 1 || L_BP < 1) begin : g_bad_len
    $error("vga_axis_timer: every phase length must be at least 1");
  end

  logic [CW-1:0] pos;
  logic [CW-1:0] last;
  logic          at_end;

  always_comb begin
    last = CW'(L_BP - 1);
    case (phase)
      ACTIVE:  last = CW'(L_ACTIVE - 1);
      FRONT:   last = CW'(L_FP - 1);
      SYNC:    last = CW'(L_SYNC - 1);
      default: last = CW'(L_BP - 1);
    endcase
  end

  assign at_end = (pos == last);
  assign wrap   = (count == CW'(TOTAL - 1));

  // phase_nxt is what phase holds after this edge, so the top can register
  // decoded outputs in lockstep with the count.
  always_comb begin
    phase_nxt = phase;
    if (step && at_end) begin
      case (phase)
        ACTIVE:  phase_nxt = FRONT;
        FRONT:   phase_nxt = SYNC;
        SYNC:    phase_nxt = BACK;
        default: phase_nxt = ACTIVE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      pos   <= '0;
      phase <= ACTIVE;
    end else if (step) begin
      count <= wrap   ? '0 : count + 1'b1;
      pos   <= at_end ? '0 : pos + 1'b1;
      phase <= phase_nxt;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: horizontal and vertical axis timers plus registered sync/video/frame outputs.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = DEF_SYNC_POL,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = cnt_w(H_TOTAL),
  localparam int VW      = cnt_w(V_TOTAL)
) (
  input  logic          clk,
  input  logic          reset,
  vga_sync_gen_if.master vga
);

  logic [HW-1:0] h_count;
  logic [VW-1:0] v_count;
  phase_t        h_phase, h_phase_nxt;
  phase_t        v_phase, v_phase_nxt;
  logic          h_wrap, v_wrap;
  logic          line_end;

  logic          hsync_r, vsync_r, video_on_r, frame_start_r;

  assign line_end = vga.pix_en & h_wrap;

  vga_axis_timer #(
    .L_ACTIVE (H_ACTIVE),
    .L_FP     (H_FP),
    .L_SYNC   (H_SYNC),
    .L_BP     (H_BP)
  ) u_h_timer (
    .clk       (clk),
    .reset     (reset),
    .step      (vga.pix_en),
    .count     (h_count),
    .phase     (h_phase),
    .phase_nxt (h_phase_nxt),
    .wrap      (h_wrap)
  );

  vga_axis_timer #(
    .L_ACTIVE (V_ACTIVE),
    .L_FP     (V_FP),
    .L_SYNC   (V_SYNC),
    .L_BP     (V_BP)
  ) u_v_timer (
    .clk       (clk),
    .reset     (reset),
    .step      (line_end),
    .count     (v_count),
    .phase     (v_phase),
    .phase_nxt (v_phase_nxt),
    .wrap      (v_wrap)
  );

  // Flags only change on a phase change, so they are loaded from phase_nxt
  // on exactly the edge where the counters cross a boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync_r       <= ~SYNC_POL;
      vsync_r       <= ~SYNC_POL;
      video_on_r    <= 1'b1;
      frame_start_r <= 1'b0;
    end else begin
      frame_start_r <= line_end & v_wrap;
      if (h_phase_nxt != h_phase) begin
        hsync_r <= (h_phase_nxt == SYNC) ? SYNC_POL : ~SYNC_POL;
      end
      if (v_phase_nxt != v_phase) begin
        vsync_r <= (v_phase_nxt == SYNC) ? SYNC_POL : ~SYNC_POL;
      end
      if ((h_phase_nxt != h_phase) || (v_phase_nxt != v_phase)) begin
        video_on_r <= (h_phase_nxt == ACTIVE) && (v_phase_nxt == ACTIVE);
      end
    end
  end

  assign vga.hcount      = h_count;
  assign vga.vcount      = v_count;
  assign vga.hsync       = hsync_r;
  assign vga.vsync       = vsync_r;
  assign vga.video_on    = video_on_r;
  assign vga.frame_start = frame_start_r;

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- VGA raster timing generator; consumes the single-cycle pixel-enable tick from the clock divider stage and advances horizontal/vertical position once per tick.
- Produces hsync/vsync pin levels, pixel coordinates, an active-video flag and a frame-start pulse for the snake renderer and game-step logic.
- All counters and outputs live in the system clock domain. No derived clocks are used.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- pix_en  in  1  one-cycle pixel tick from divider; position advances only when high
- hsync  out  1  horizontal sync pin level
- vsync  out  1  vertical sync pin level
- video_on  out  1  current position inside the active area
- hcount  out  $clog2(H_TOTAL)  pixel column, 0..H_TOTAL-1 (H_TOTAL = sum of H_*)
- vcount  out  $clog2(V_TOTAL)  line, 0..V_TOTAL-1 (V_TOTAL = sum of V_*)
- frame_start  out  1  one-clk pulse on entry to position (0,0)

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high. Reset takes priority over pix_en.
- Reset values: hcount=0, vcount=0, both phases ACTIVE, video_on=1, hsync=vsync=~SYNC_POL, frame_start=0.
- Each axis runs a phase FSM: ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE.
  - Each phase holds for its parameter length.
  - Transitions occur only on a clk edge where the axis is stepped and its in-phase position equals length-1.
- Horizontal axis stepping:
  - Stepped on every clk edge with pix_en=1.
  - hcount increments, wrapping H_TOTAL-1 -> 0.
  - The wrap asserts an internal line_end step to the vertical axis on the same edge.
- Vertical axis stepping:
  - Stepped only when pix_en=1 and hcount==H_TOTAL-1.
  - vcount increments, wrapping V_TOTAL-1 -> 0.
- pix_en=0: every register holds, including outputs. frame_start drops to 0 after its single-cycle pulse.
- All outputs are registered and consistent with the hcount/vcount values presented in the same cycle (zero skew between count and sync/video flags).
  - hsync = SYNC_POL iff hphase==SYNC. With defaults, asserted for hcount 656..751.
  - vsync = SYNC_POL iff vphase==SYNC. With defaults, asserted for vcount 490..491.
  - video_on = (hphase==ACTIVE && vphase==ACTIVE).
- frame_start is 1 for exactly one clk: the cycle in which counts first read (0,0) after a wrap from (H_TOTAL-1, V_TOTAL-1). It is not asserted by reset.
- Reset mid-frame: the next cycle shows the reset values. The timing restarts at (0,0) with no frame_start for that partial frame.
- pix_en arriving every clk, or irregularly, is legal. Timing is counted purely in ticks.
- Widths: counters are sized from totals. No arithmetic overflow is possible, since wrap is explicit and does not rely on natural rollover.
- Parameter elaboration checks: every length >= 1. With defaults, H_TOTAL=800 and V_TOTAL=525 (10-bit counts).

Decomposition:
- vga_pkg holds:
  - the phase enum typedef (ACTIVE, FRONT, SYNC, BACK)
  - default 640x480@60 timing constants, used as parameter defaults
- Sub-module vga_axis_timer:
  - parameterized by the four lengths
  - inputs clk, reset, step
  - outputs count, phase, wrap
  - instantiated once for horizontal, once for vertical (step = pix_en & h_wrap)
- Top level adds output registers/decoding and frame_start generation.

Test Plan:
- Reset, then pix_en=1 continuously -> hsync goes low at hcount=656, high at hcount=752. video_on falls at hcount=640 and rises at the wrap to 0. vcount increments exactly when hcount 799->0.
- Run 800*525 pix_en ticks from reset -> frame_start pulses once, for 1 clk, when counts read (0,0). vsync is low only on vcount 490 and 491.
- pix_en asserted every 4th clk -> counts advance once per 4 clks. frame_start period is 4*420000 clks. All outputs hold between ticks.
- pix_en held 0 for 100 clks mid-line at hcount=655 -> all outputs frozen. The next tick moves to 656 with hsync asserted.
- reset asserted at hcount=700, vcount=300 -> next cycle shows hcount=0, vcount=0, video_on=1, hsync=vsync=1, frame_start=0.
- Override parameters to small values (H 4/1/2/1, V 3/1/1/1) -> phase boundaries and the wrap checked at every position over two full frames against a reference model.
